// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default
// bit timing.
package uart_pkg;

    // Default number of system clocks per serial bit.
    localparam int CLKS_PER_BIT_DEFAULT = 8;

    // Number of data bits in an 8N1 frame.
    localparam int DATA_BITS = 8;

    // Receiver FSM states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Both flops reset to
// RESET_VAL so the synchronized output has a defined value out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to resolve metastability.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments let both flops sample their inputs
            // from before the edge; blocking here would collapse the chain to
            // a single flop.
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The serial line is synchronized, the start bit is
// qualified at its midpoint, and every following bit is sampled one bit
// period later so all samples land near bit centres.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte
);

    // Reject bit timings too short to locate a mid-bit sample point.
    if (CLKS_PER_BIT < 4) begin : g_bad_param
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts: middle of the start bit, and one full bit period.
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    rx_state_t            state_q,   state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 rx_dv_q,   rx_dv_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;

    logic rx_sync;

    // Bring the asynchronous line into the clock domain; idles high.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx_serial),
        .o_q   (rx_sync)
    );

    // State, counters, shift register and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_dv_q   <= 1'b0;
            rx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_dv_q   <= rx_dv_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    // Next-state logic: walk the frame, sampling the line only at mid-bit.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // leaves a value unassigned and infers a latch.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_dv_d   = 1'b0;
        rx_byte_d = rx_byte_q;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_sync) begin
                    state_d = START;
                end
            end

            START: begin
                if (clk_cnt_q == CNT_MID) begin
                    clk_cnt_d = '0;
                    // A line already back high at mid start bit was a glitch.
                    state_d   = rx_sync ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_sync;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    // A low stop bit is a framing error: the byte is dropped
                    // and the previously published byte stays visible.
                    if (rx_sync) begin
                        rx_byte_d = shift_q;
                        rx_dv_d   = 1'b1;
                    end
                    state_d = CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            CLEANUP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rx_dv   = rx_dv_q;
    assign o_rx_byte = rx_byte_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, glitch, framing error,
// mid-frame reset and a run of random bytes, all checked against a queue of
// bytes the receiver is expected to deliver.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       i_clk       = 1'b0;
    logic       i_rst       = 1'b1;
    logic       i_rx_serial = 1'b1;
    logic       o_rx_dv;
    logic [7:0] o_rx_byte;

    int vectors     = 0;
    int miscompares = 0;
    int dv_count    = 0;

    // Reference model: bytes still owed by the receiver, and the byte that
    // should currently be presented on o_rx_byte.
    logic [7:0] exp_q[$];
    logic [7:0] model_byte = 8'h00;

    logic       prev_dv   = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       rst_edge  = 1'b1;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_serial (i_rx_serial),
        .o_rx_dv     (o_rx_dv),
        .o_rx_byte   (o_rx_byte)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled 1 ns after each rising edge.
    always @(posedge i_clk) begin
        logic [7:0] exp_b;
        rst_edge = i_rst;
        #1;
        if (o_rx_dv === 1'b1) begin
            dv_count++;
            check("dv_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                check("dv_byte", o_rx_byte, exp_b);
            end
            check("dv_single_cycle", prev_dv, 0);
        end
        if (!rst_edge && o_rx_byte !== prev_byte) begin
            check("byte_changes_with_dv", o_rx_dv, 1);
        end
        prev_dv   = o_rx_dv;
        prev_byte = o_rx_byte;
    end

    task automatic send_bit(input logic b);
        i_rx_serial = b;
        repeat (CPB) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back(data);
            model_byte = data;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop_ok);
    endtask

    task automatic idle(input int n);
        i_rx_serial = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_dv(input int target, input string tag);
        int budget;
        budget = 4 * CPB;
        while (dv_count < target && budget > 0) begin
            @(negedge i_clk);
            budget--;
        end
        check(tag, dv_count, target);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic [7:0] abort_data;
        int         base;

        // Reset for 100 ns with the line idle.
        i_rst       = 1'b1;
        i_rx_serial = 1'b1;
        repeat (10) @(negedge i_clk);
        check("reset_dv", o_rx_dv, 0);
        check("reset_byte", o_rx_byte, 8'h00);
        i_rst = 1'b0;
        idle(2 * CPB);

        // Single frame, bits 1,0,0,1,1,0,1,0 LSB first.
        send_frame(8'h59, 1'b1);
        wait_dv(1, "dv_count_59");
        check("byte_59", o_rx_byte, model_byte);
        idle(2 * CPB);

        // Back-to-back frames with a stop bit of exactly one bit period.
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_dv(3, "dv_count_back_to_back");
        check("byte_3c", o_rx_byte, model_byte);
        idle(2 * CPB);

        // Three-clock low glitch on the idle line.
        i_rx_serial = 1'b0;
        repeat (3) @(negedge i_clk);
        idle(3 * CPB);
        check("glitch_no_dv", dv_count, 3);
        check("glitch_byte_held", o_rx_byte, model_byte);

        // Framing error, then a good frame of all zeros.
        send_frame(8'hFF, 1'b0);
        idle(2 * CPB);
        check("framing_no_dv", dv_count, 3);
        check("framing_byte_held", o_rx_byte, model_byte);
        send_frame(8'h00, 1'b1);
        wait_dv(4, "dv_count_00");
        check("byte_00", o_rx_byte, model_byte);
        idle(2 * CPB);

        // Load a nonzero byte so the reset clearing it is visible.
        send_frame(8'hC3, 1'b1);
        wait_dv(5, "dv_count_c3");
        check("byte_c3", o_rx_byte, model_byte);
        idle(2 * CPB);

        // Reset in the middle of data bit 4.
        abort_data = 8'h6E;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(abort_data[i]);
        i_rx_serial = abort_data[4];
        repeat (CPB / 2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midreset_dv", o_rx_dv, 0);
        check("midreset_byte", o_rx_byte, 8'h00);
        model_byte  = 8'h00;
        i_rst       = 1'b0;
        idle(3 * CPB);
        check("midreset_no_dv", dv_count, 5);
        send_frame(8'h81, 1'b1);
        wait_dv(6, "dv_count_81");
        check("byte_81", o_rx_byte, model_byte);
        idle(2 * CPB);

        // Twenty random bytes with random idle gaps, including none.
        base = dv_count;
        for (int n = 0; n < 20; n++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1);
            idle(CPB * $urandom_range(0, 2));
        end
        wait_dv(base + 20, "dv_count_random");
        check("random_last_byte", o_rx_byte, model_byte);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 8, clock cycles per serial bit (integer, minimum 4).
REQ-002 SHALL have port: i_clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: i_rx_serial  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: o_rx_dv  output  1  one-cycle pulse, o_rx_byte newly valid.
REQ-006 SHALL have port: o_rx_byte  output  8  last correctly framed received byte.

Function
REQ-007 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, no parity, stop bit 1.
REQ-008 SHALL pass i_rx_serial through a 2-flop synchronizer, reset value 1; all FSM decisions use the synchronized bit (2-cycle input latency).
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP, CLEANUP.
REQ-010 IDLE: bit counter cleared; synchronized line 0 -> START with clock counter 0.
REQ-011 START: at count CLKS_PER_BIT/2-1 (mid start bit), line still 0 -> DATA with counter 0; line 1 -> IDLE (glitch rejected, no output change).
REQ-012 DATA: every CLKS_PER_BIT cycles (mid-bit) sample line into bit index 0..7 of the shift register; after index 7 -> STOP.
REQ-013 STOP: after CLKS_PER_BIT cycles (mid stop bit) sample line; 1 -> copy shift register to o_rx_byte, pulse o_rx_dv, go to CLEANUP; 0 -> framing error, byte discarded, no dv, go to CLEANUP.
REQ-014 CLEANUP: one cycle, o_rx_dv deasserted, -> IDLE; next start edge accepted from the following cycle (half stop bit allows back-to-back frames).
REQ-015 o_rx_dv SHALL be registered, high exactly one clock per good frame, never high in two consecutive cycles.
REQ-016 o_rx_byte SHALL change only in the cycle o_rx_dv rises and hold its value otherwise (including after framing errors).
REQ-017 Clock counter width SHALL be $clog2(CLKS_PER_BIT), bit index 3 bits; counters never wrap past their terminal values.
REQ-018 Line transitions within a bit period other than at the sample points SHALL be ignored.

Reset
REQ-019 While i_rst=1 at a rising edge: FSM -> IDLE, counters 0, shift register 0, o_rx_dv 0, o_rx_byte 8'h00, synchronizer flops 1.
REQ-020 Reset mid-frame SHALL abort the frame with no dv; reception restarts on the next falling edge after release.

Structure
REQ-021 Package uart_pkg SHALL hold the FSM state enum (rx_state_t) and the default CLKS_PER_BIT constant.
REQ-022 The input synchronizer SHALL be a sub-module sync_2ff (1-bit, reset value parameter); all else in uart_rx.

Verification
REQ-023 CLKS_PER_BIT=8, reset 100 ns, idle high, then frame start, bits 1,0,0,1,1,0,1,0, stop 1 -> single o_rx_dv pulse, o_rx_byte=8'h59.
REQ-024 Two back-to-back frames 8'hA5 then 8'h3C, stop bit exactly 8 clocks -> two dv pulses, bytes A5 then 3C in order.
REQ-025 Low glitch of 3 clocks on idle line -> no dv, FSM back to IDLE, o_rx_byte unchanged.
REQ-026 Frame 8'hFF with stop bit 0 -> no dv, o_rx_byte keeps previous value; next good frame 8'h00 -> dv, byte 8'h00.
REQ-027 i_rst asserted during data bit 4 of a frame -> outputs 0 next cycle, no dv; subsequent frame 8'h81 received correctly.
REQ-028 Count dv pulses against frames sent over 20 random bytes -> equal count, each byte matches.
